// File: rtl/light_dance_pkg.sv
`default_nettype none
// ============================================================================
// Module   : light_dance_pkg
// Brief    : Shared state encoding and defaults for the light-dance LFSR.
// Revision : 1.0
// ============================================================================
package light_dance_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [7:0] c_POLY_DEFAULT  = 8'h33;
  localparam int         c_CNT_W_DEFAULT = 16;

endpackage
`default_nettype wire

// File: rtl/light_dance_lfsr_step.sv
`default_nettype none
// ============================================================================
// Module   : lfsr_step
// Brief    : One combinational Galois LFSR shift; serial input enters the MSB.
// Revision : 1.0
// ============================================================================
module lfsr_step
  import light_dance_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(c_POLY_DEFAULT)
) (
  input  logic [WIDTH-1:0] q,
  input  logic             din,
  output logic [WIDTH-1:0] next
);

  for (genvar i = 0; i < WIDTH - 1; i++) begin : g_tap
    assign next[i] = POLY[i] ? (q[i+1] ^ q[0]) : q[i+1];
  end

  assign next[WIDTH-1] = din ^ q[0];

endmodule
`default_nettype wire

// File: rtl/light_dance_lfsr.sv
`default_nettype none
// ============================================================================
// Module   : light_dance_lfsr
// Brief    : Parametrised Galois LFSR with counted burst mode and handshake.
//            Optional seed-match pulse on `wrap` when LIGHT_DANCE_WRAP_EN is set.
// Revision : 1.0
// ============================================================================
module light_dance_lfsr
  import light_dance_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(c_POLY_DEFAULT),
  parameter int               CNT_W = c_CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             din,
  input  logic             load,
  input  logic [WIDTH-1:0] pdata,
  input  logic             shift_en,
  input  logic             start,
  input  logic [CNT_W-1:0] steps,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] remaining,
  output logic [WIDTH-1:0] qdata
`ifdef LIGHT_DANCE_WRAP_EN
  ,
  output logic             wrap
`endif
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_step;
  logic [WIDTH-1:0] w_q_nxt;
  logic [CNT_W-1:0] r_rem;
  logic [CNT_W-1:0] w_rem_nxt;
  logic             w_shift;

  lfsr_step #(
    .WIDTH (WIDTH),
    .POLY  (POLY)
  ) u_step (
    .q    (r_q),
    .din  (din),
    .next (w_step)
  );

  always_ff @(posedge clk) begin
    if (arst) begin
      r_state <= ST_IDLE;
      r_q     <= '0;
      r_rem   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_q     <= w_q_nxt;
      r_rem   <= w_rem_nxt;
    end
  end

  // Priority: load > RUN shift > start acceptance > shift_en > hold.
  always_comb begin
    w_state_nxt = r_state;
    w_rem_nxt   = r_rem;
    w_shift     = 1'b0;
    if (load) begin
      w_state_nxt = ST_IDLE;
      w_rem_nxt   = '0;
    end else if (r_state == ST_RUN) begin
      w_shift     = 1'b1;
      w_rem_nxt   = r_rem - CNT_W'(1);
      w_state_nxt = (r_rem == CNT_W'(1)) ? ST_DONE : ST_RUN;
    end else if (start) begin
      w_rem_nxt   = steps;
      w_state_nxt = (steps == '0) ? ST_DONE : ST_RUN;
    end else begin
      w_state_nxt = ST_IDLE;
      w_shift     = shift_en;
    end
    w_q_nxt = load ? pdata : (w_shift ? w_step : r_q);
  end

  always_comb begin
    busy      = (r_state == ST_RUN);
    done      = (r_state == ST_DONE);
    remaining = r_rem;
    qdata     = r_q;
  end

`ifdef LIGHT_DANCE_WRAP_EN
  logic [WIDTH-1:0] r_seed;
  logic             r_wrap;

  always_ff @(posedge clk) begin
    if (arst) begin
      r_seed <= '0;
      r_wrap <= 1'b0;
    end else begin
      if (load) begin
        r_seed <= pdata;
      end
      r_wrap <= w_shift && (w_q_nxt == r_seed);
    end
  end

  assign wrap = r_wrap;
`endif

endmodule
`default_nettype wire

// File: tb/tb_light_dance_lfsr.sv
`default_nettype none
// ============================================================================
// Module   : tb_light_dance_lfsr
// Brief    : Self-checking bench for light_dance_lfsr against a behavioural model.
// Revision : 1.0
// ============================================================================
module tb_light_dance_lfsr;

  localparam logic [7:0] c_POLY = 8'h33;

  logic        clk = 1'b0;
  logic        arst, din, load, shift_en, start;
  logic [7:0]  pdata;
  logic [15:0] steps;
  logic        busy, done;
  logic [15:0] remaining;
  logic [7:0]  qdata;
`ifdef LIGHT_DANCE_WRAP_EN
  logic        wrap;
  logic        w3_load, w3_shift;
  logic [2:0]  w3_pdata;
  logic        w3_busy, w3_done, w3_wrap;
  logic [3:0]  w3_rem;
  logic [2:0]  w3_q;
`endif

  light_dance_lfsr #(.WIDTH(8), .POLY(c_POLY), .CNT_W(16)) dut (
    .clk       (clk),
    .arst      (arst),
    .din       (din),
    .load      (load),
    .pdata     (pdata),
    .shift_en  (shift_en),
    .start     (start),
    .steps     (steps),
    .busy      (busy),
    .done      (done),
    .remaining (remaining),
    .qdata     (qdata)
`ifdef LIGHT_DANCE_WRAP_EN
    ,
    .wrap      (wrap)
`endif
  );

`ifdef LIGHT_DANCE_WRAP_EN
  light_dance_lfsr #(.WIDTH(3), .POLY(3'b001), .CNT_W(4)) dut3 (
    .clk       (clk),
    .arst      (arst),
    .din       (1'b0),
    .load      (w3_load),
    .pdata     (w3_pdata),
    .shift_en  (w3_shift),
    .start     (1'b0),
    .steps     (4'd0),
    .busy      (w3_busy),
    .done      (w3_done),
    .remaining (w3_rem),
    .qdata     (w3_q),
    .wrap      (w3_wrap)
  );
`endif

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  logic [7:0]  m_q, m_seed;
  logic [15:0] m_left;
  logic        m_busy, m_done, m_wrap;

  // Galois step as arithmetic: halve, inject din at the top, fold taps on carry-out.
  function automatic logic [7:0] ref_step(input logic [7:0] q, input logic d);
    int v;
    v = int'(q) / 2 + (d ? 128 : 0);
    if (int'(q) % 2 == 1) v = v ^ (int'(c_POLY) & 8'h7F) ^ 8'h80;
    return 8'(v);
  endfunction

  task automatic tick(input logic a, input logic l, input logic [7:0] pd,
                      input logic s, input logic [15:0] n,
                      input logic se, input logic d);
    logic sh;
    sh = 1'b0;
    arst = a; load = l; pdata = pd; start = s; steps = n; shift_en = se; din = d;
    if (a) begin
      m_q = '0; m_left = '0; m_busy = 1'b0; m_done = 1'b0; m_seed = '0;
    end else if (l) begin
      m_q = pd; m_seed = pd; m_left = '0; m_busy = 1'b0; m_done = 1'b0;
    end else if (m_busy) begin
      m_q = ref_step(m_q, d); sh = 1'b1;
      m_left = m_left - 16'd1;
      m_busy = (m_left != 0);
      m_done = (m_left == 0);
    end else if (s) begin
      m_left = n; m_busy = (n != 0); m_done = (n == 0);
    end else begin
      m_done = 1'b0;
      if (se) begin
        m_q = ref_step(m_q, d); sh = 1'b1;
      end
    end
    m_wrap = sh && (m_q == m_seed);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic d);
    tick(1'b0, 1'b0, 8'h00, 1'b0, 16'd0, 1'b0, d);
  endtask

  task automatic test_reset();
    tick(1'b1, 1'b0, 8'h00, 1'b0, 16'd0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 8'h00, 1'b0, 16'd0, 1'b0, 1'b0);
    checks++;
    if (qdata !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || remaining !== 16'd0) begin
      errors++;
      $display("FAIL reset: q=%h busy=%b done=%b rem=%0d, required 00/0/0/0",
               qdata, busy, done, remaining);
    end
    idle(1'b0);
  endtask

  task automatic test_single_shift();
    logic [7:0] seeds [3] = '{8'h01, 8'h80, 8'h00};
    logic       dins  [3] = '{1'b0, 1'b0, 1'b1};
    logic [7:0] exps  [3] = '{8'hB3, 8'h40, 8'h80};
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b1, seeds[i], 1'b0, 16'd0, 1'b0, 1'b0);
      tick(1'b0, 1'b0, 8'h00, 1'b0, 16'd0, 1'b1, dins[i]);
      checks++;
      if (qdata !== exps[i] || qdata !== m_q || busy !== 1'b0) begin
        errors++;
        $display("FAIL single_shift[%0d]: q=%h busy=%b, required q=%h busy=0",
                 i, qdata, busy, exps[i]);
      end
    end
  endtask

  task automatic test_burst();
    logic [7:0] seq [8] = '{8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'hB3};
    int dones;
    dones = 0;
    tick(1'b0, 1'b1, 8'h80, 1'b0, 16'd0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 8'h00, 1'b1, 16'd8, 1'b0, 1'b0);
    checks++;
    if (busy !== 1'b1 || remaining !== 16'd8 || qdata !== 8'h80) begin
      errors++;
      $display("FAIL burst_accept: busy=%b rem=%0d q=%h, required 1/8/80", busy, remaining, qdata);
    end
    for (int k = 1; k <= 8; k++) begin
      idle(1'b0);
      if (done === 1'b1) dones++;
      checks++;
      if (qdata !== seq[k-1] || busy !== (k < 8) || remaining !== 16'(8 - k) ||
          done !== (k == 8)) begin
        errors++;
        $display("FAIL burst_step[%0d]: q=%h busy=%b done=%b rem=%0d, required q=%h busy=%b done=%b rem=%0d",
                 k, qdata, busy, done, remaining, seq[k-1], (k < 8), (k == 8), 8 - k);
      end
    end
    idle(1'b0);
    if (done === 1'b1) dones++;
    checks++;
    if (dones != 1 || busy !== 1'b0 || qdata !== 8'hB3) begin
      errors++;
      $display("FAIL burst_end: done_pulses=%0d busy=%b q=%h, required 1/0/B3", dones, busy, qdata);
    end
  endtask

  task automatic test_zero_burst();
    tick(1'b0, 1'b1, 8'h3C, 1'b0, 16'd0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 8'h00, 1'b1, 16'd0, 1'b1, 1'b1);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || qdata !== 8'h3C || remaining !== 16'd0) begin
      errors++;
      $display("FAIL zero_burst: done=%b busy=%b q=%h rem=%0d, required 1/0/3C/0",
               done, busy, qdata, remaining);
    end
    idle(1'b0);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_burst_after: done=%b busy=%b, required 0/0", done, busy);
    end
  endtask

  task automatic test_abort();
    int dones;
    dones = 0;
    tick(1'b0, 1'b1, 8'h80, 1'b0, 16'd0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 8'h00, 1'b1, 16'd10, 1'b0, 1'b0);
    idle(1'b1);
    idle(1'b0);
    tick(1'b0, 1'b1, 8'h5A, 1'b1, 16'd4, 1'b0, 1'b0);
    checks++;
    if (qdata !== 8'h5A || busy !== 1'b0 || done !== 1'b0 || remaining !== 16'd0) begin
      errors++;
      $display("FAIL abort: q=%h busy=%b done=%b rem=%0d, required 5A/0/0/0",
               qdata, busy, done, remaining);
    end
    for (int k = 0; k < 4; k++) begin
      idle(1'b0);
      if (done === 1'b1 || busy === 1'b1) dones++;
    end
    checks++;
    if (dones != 0 || qdata !== 8'h5A) begin
      errors++;
      $display("FAIL abort_quiet: activity_cycles=%0d q=%h, required 0/5A", dones, qdata);
    end
  endtask

  task automatic test_start_in_run();
    tick(1'b0, 1'b1, 8'hC3, 1'b0, 16'd0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 8'h00, 1'b1, 16'd5, 1'b0, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      tick(1'b0, 1'b0, 8'h00, 1'b1, 16'd100, 1'b1, 1'($urandom_range(0, 1)));
      checks++;
      if (remaining !== 16'(5 - k) || qdata !== m_q || busy !== (k < 5) || done !== (k == 5)) begin
        errors++;
        $display("FAIL start_in_run[%0d]: rem=%0d q=%h busy=%b done=%b, required rem=%0d q=%h busy=%b done=%b",
                 k, remaining, qdata, busy, done, 5 - k, m_q, (k < 5), (k == 5));
      end
    end
    idle(1'b0);
  endtask

  task automatic test_reset_mid_burst();
    tick(1'b0, 1'b1, 8'hA5, 1'b0, 16'd0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 8'h00, 1'b1, 16'd6, 1'b0, 1'b0);
    idle(1'b1);
    idle(1'b0);
    tick(1'b1, 1'b0, 8'h00, 1'b0, 16'd0, 1'b0, 1'b0);
    checks++;
    if (qdata !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || remaining !== 16'd0) begin
      errors++;
      $display("FAIL reset_mid_burst: q=%h busy=%b done=%b rem=%0d, required 00/0/0/0",
               qdata, busy, done, remaining);
    end
    tick(1'b0, 1'b1, 8'h01, 1'b0, 16'd0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 8'h00, 1'b1, 16'd3, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) idle(1'b0);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || qdata !== m_q) begin
      errors++;
      $display("FAIL post_reset_burst: done=%b busy=%b q=%h, required 1/0/%h", done, busy, qdata, m_q);
    end
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    for (int c = 0; c < 600; c++) begin
      int r;
      r = int'($urandom_range(0, 99));
      tick(1'(r < 2), 1'(r >= 2 && r < 10), 8'($urandom),
           1'(r >= 10 && r < 22), 16'($urandom_range(0, 12)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      checks++;
      if (qdata !== m_q || busy !== m_busy || done !== m_done || remaining !== m_left
`ifdef LIGHT_DANCE_WRAP_EN
          || wrap !== m_wrap
`endif
         ) begin
        errors++;
        bad++;
        if (bad <= 10)
          $display("FAIL random[%0d]: q=%h busy=%b done=%b rem=%0d, required q=%h busy=%b done=%b rem=%0d",
                   c, qdata, busy, done, remaining, m_q, m_busy, m_done, m_left);
      end
    end
  endtask

`ifdef LIGHT_DANCE_WRAP_EN
  task automatic test_wrap();
    logic [2:0] seq [7] = '{3'b101, 3'b111, 3'b110, 3'b011, 3'b100, 3'b010, 3'b001};
    w3_load = 1'b1; w3_pdata = 3'b001; w3_shift = 1'b0;
    @(posedge clk); #1;
    w3_load = 1'b0; w3_shift = 1'b1;
    for (int k = 0; k < 21; k++) begin
      @(posedge clk); #1;
      checks++;
      if (w3_q !== seq[k % 7] || w3_wrap !== (k % 7 == 6)) begin
        errors++;
        $display("FAIL wrap[%0d]: q=%b wrap=%b, required q=%b wrap=%b",
                 k, w3_q, w3_wrap, seq[k % 7], (k % 7 == 6));
      end
    end
    w3_shift = 1'b0;
  endtask
`endif

  initial begin
    arst = 1'b1; load = 1'b0; pdata = '0; start = 1'b0; steps = '0; shift_en = 1'b0; din = 1'b0;
    m_q = '0; m_seed = '0; m_left = '0; m_busy = 1'b0; m_done = 1'b0; m_wrap = 1'b0;
`ifdef LIGHT_DANCE_WRAP_EN
    w3_load = 1'b0; w3_shift = 1'b0; w3_pdata = '0;
`endif
    test_reset();
    test_single_shift();
    test_burst();
    test_zero_burst();
    test_abort();
    test_start_in_run();
    test_reset_mid_burst();
`ifdef LIGHT_DANCE_WRAP_EN
    test_wrap();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/light_dance_lfsr.md
# light_dance_lfsr

Parametrised Galois LFSR engine for the smart-home lighting controller. It generalises the fixed 8-bit light-dance shift register: width and feedback polynomial are configurable, and it adds a counted burst mode with a start/busy/done handshake. It drives the lamp pattern bus directly from `qdata`, and the scene sequencer controls it through `load`, `shift_en` and `start`.

## Interface
Parameters:
- `WIDTH`, 8: register width, at least 2.
- `POLY`, `8'h33` (WIDTH bits): tap mask.
  - Bit i set (i < WIDTH-1) means `next[i] = q[i+1] ^ q[0]`.
  - Bit i clear means `next[i] = q[i+1]`.
  - Bit WIDTH-1 is ignored.
- `CNT_W`, 16: width of the burst step counter.

Ports:
- `clk` in 1: clock, posedge.
- `arst` in 1: reset, synchronous and active-high.
- `din` in 1: serial data input; `next[WIDTH-1] = din ^ q[0]`.
- `load` in 1: parallel load enable.
- `pdata` in WIDTH: parallel load value.
- `shift_en` in 1: one shift per cycle while idle.
- `start` in 1: request a burst of `steps` shifts.
- `steps` in CNT_W: burst length, sampled with `start`.
- `busy` out 1: burst in progress.
- `done` out 1: one-cycle pulse when a burst completes.
- `remaining` out CNT_W: shifts left in the current burst.
- `qdata` out WIDTH: register state.
- `wrap` out 1: only when `LIGHT_DANCE_WRAP_EN` is defined.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- Per-edge priority: `arst` > `load` > RUN shift > `start` acceptance > `shift_en` shift > hold.
- `load` writes `pdata` to `qdata`.
  - In RUN, `load` aborts the burst: next state IDLE, `remaining`=0, no `done` pulse.
  - `start` in the same cycle as `load` is dropped.
- `start` is accepted in IDLE or DONE.
  - `steps`=N>0: `remaining`=N, next state RUN, no shift on the accepting edge.
  - `steps`=0: next state DONE, `qdata` unchanged, `busy` never asserts.
- RUN: every edge shifts once, sampling `din`, and decrements `remaining`. The edge where `remaining`=1 goes to DONE.
- `start` and `shift_en` are ignored in RUN.
- DONE lasts one cycle (`done`=1), then IDLE, unless a new `start` is accepted.
  - `shift_en` is honoured in DONE and IDLE when `start` is low.
  - If `start` and `shift_en` are both high in IDLE or DONE, `start` wins and no shift occurs on that edge.
- An all-zero state with `din`=0 stays all-zero. This is legal and is not flagged.
- `remaining` wraps never: N is at most 2^CNT_W-1, and `start` is not accepted in RUN.

## Timing
- Reset values: `qdata`=0, `busy`=0, `done`=0, `remaining`=0, `wrap`=0, state IDLE.
- `arst` mid-burst returns every output to its reset value on the next edge.
- Burst latency, with `start` accepted at edge 0:
  - `busy`=1 after edges 0..N-1.
  - Shifts occur at edges 1..N.
  - `done`=1 and `busy`=0 during the cycle after edge N.
- `shift_en` and `load` take effect on the same edge they are sampled; all outputs are registered.

## Configuration
- `LIGHT_DANCE_WRAP_EN` defined:
  - A seed register captures `pdata` on every `load`.
  - `wrap` pulses high for one cycle after any shift edge where the new `qdata` equals the seed.
  - The seed resets to 0.
- Not defined: no seed register, no `wrap` port, behaviour otherwise identical.

## Structure
- `light_dance_pkg` holds:
  - the state enum (IDLE/RUN/DONE);
  - the default `POLY` constant;
  - the `CNT_W` default.
- Sub-module `lfsr_step`: purely combinational, with inputs `q`, `din` and parameter `POLY`, output `next`. It is instantiated once.

## Test plan
All cases use WIDTH=8 and POLY=8'h33 unless stated.
- Single shifts:
  - load 8'h01, `shift_en` one cycle, `din`=0 -> `qdata`=8'hB3.
  - load 8'h80, same stimulus -> 8'h40.
  - load 0, `din`=1 -> 8'h80.
- Burst: load 8'h80, `start` with `steps`=8, `din`=0 -> `qdata` 40,20,...,01,B3; `busy` high for 8 cycles; `done` pulses once, 9 cycles after `start`; final `qdata`=8'hB3.
- Zero-step burst: `start` with `steps`=0 -> `done` pulses the next cycle, `busy` stays 0, `qdata` unchanged.
- Abort:
  - `load` 8'h5A at the third RUN cycle -> `qdata`=8'h5A, `busy` low next cycle, no `done`.
  - `start` during RUN is ignored: `remaining` keeps counting down.
- Reset mid-burst: `arst` during RUN -> all outputs 0 on the next edge; a new `start` afterwards works normally.
- Wrap (macro on, WIDTH=3, POLY=3'b001): load 3'b001, hold `shift_en` with `din`=0 -> sequence 101,111,110,011,100,010,001; `wrap` pulses after the 7th shift and every 7 shifts thereafter.
